ahb_arbiter: RTL and testbench

- Sits directly downstream of the per-manager input stages in the AHB multi-manager interconnect.
- Takes the (possibly stored) request from each input stage and arbitrates address-phase ownership.
- Returns GRANT (address-phase owner) and GRANTD (data-phase owner) to every input stage.
- Drives one merged AHBManager request onto the shared subordinate bus: address/control from the GRANT owner, HWDATA from the GRANTD owner.

---
 rtl/ahbspec.sv | 20 ++
 rtl/ahb_arbiter_rr_pick.sv | 29 ++
 rtl/ahb_arbiter.sv | 91 +++++++++
 tb/tb_ahb_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahbspec.sv
// Shared AHB definitions: HTRANS encodings and the per-manager request bundle
// seen by the interconnect arbitration stage.
package ahbspec;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef struct packed {
        logic [31:0] HADDR;
        logic [1:0]  HTRANS;
        logic        HWRITE;
        logic [2:0]  HSIZE;
        logic [2:0]  HBURST;
        logic [3:0]  HPROT;
        logic [31:0] HWDATA;
    } AHBManager;

endpackage

// File: rtl/ahb_arbiter_rr_pick.sv
// Combinational pick of the first set bit in active_i, scanning upward from
// start_i and wrapping at N-1 (N need not be a power of two).
module ahb_rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] active_i,
    input  logic [W-1:0] start_i,
    output logic [W-1:0] idx_o,
    output logic         found_o
);

    always_comb begin
        int c;
        c       = 0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            // start_i is always < N, so one subtraction is enough to wrap
            c = int'(start_i) + k;
            if (c >= N) c = c - N;
            if (!found_o && active_i[c]) begin
                found_o = 1'b1;
                idx_o   = W'(c);
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Address/data-phase arbiter for the shared subordinate path. Round-robin by
// default; define AHB_ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
module ahb_arbiter
    import ahbspec::*;
#(
    parameter int NUM_MANAGERS = 2,
    parameter int RESET_OWNER  = 0
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  AHBManager [NUM_MANAGERS-1:0]  inRequest,
    input  logic [NUM_MANAGERS-1:0]       HSEL,
    input  logic                          HREADY,
    output logic [NUM_MANAGERS-1:0]       GRANT,
    output logic [NUM_MANAGERS-1:0]       GRANTD,
    output AHBManager                     outRequest
);

    localparam int IW = $clog2(NUM_MANAGERS);
    localparam logic [IW-1:0] RST_IDX = IW'(RESET_OWNER);

    logic [NUM_MANAGERS-1:0] active;
    logic [IW-1:0]           owner_q, owner_d;
    logic [IW-1:0]           didx_q;
    logic                    dvld_q;
    logic [IW-1:0]           start;
    logic [IW-1:0]           pick_idx;
    logic                    pick_found;
    logic                    owner_active;
    logic                    owner_seq;

    always_comb begin
        for (int i = 0; i < NUM_MANAGERS; i++)
            active[i] = HSEL[i] && (inRequest[i].HTRANS != HTRANS_IDLE);
    end

    assign owner_active = active[owner_q];
    assign owner_seq    = owner_active && (inRequest[owner_q].HTRANS == HTRANS_SEQ);

`ifdef AHB_ARB_FIXED_PRIORITY_EN
    assign start = '0;
`else
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MANAGERS - 1);
    logic [IW-1:0] rr_q, rr_d;

    assign start = (rr_q == LAST_IDX) ? '0 : rr_q + 1'b1;
    assign rr_d  = (owner_d != owner_q) ? owner_d : rr_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)    rr_q <= RST_IDX;
        else if (HREADY) rr_q <= rr_d;
    end
`endif

    ahb_rr_pick #(.N(NUM_MANAGERS), .W(IW)) u_pick (
        .active_i (active),
        .start_i  (start),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    // A SEQ beat from the owner pins the bus; with nobody active the grant parks
    assign owner_d = (!owner_seq && pick_found) ? pick_idx : owner_q;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_q <= RST_IDX;
            dvld_q  <= 1'b0;
            didx_q  <= RST_IDX;
        end else if (HREADY) begin
            owner_q <= owner_d;
            dvld_q  <= owner_active;
            didx_q  <= owner_q;
        end
    end

    always_comb begin
        GRANT           = '0;
        GRANT[owner_q]  = 1'b1;
        GRANTD          = '0;
        if (dvld_q) GRANTD[didx_q] = 1'b1;
    end

    always_comb begin
        outRequest = inRequest[owner_q];
        if (!owner_active) outRequest.HTRANS = HTRANS_IDLE;
        outRequest.HWDATA = dvld_q ? inRequest[didx_q].HWDATA : 32'h0;
        if (!HRESETn) outRequest = '0;
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Scoreboard bench for ahb_arbiter with three managers (non-power-of-two wrap).
module tb_ahb_arbiter;
    import ahbspec::*;

    localparam int N = 3;

    logic               HCLK = 1'b0;
    logic               HRESETn;
    AHBManager [N-1:0]  inRequest;
    logic [N-1:0]       HSEL;
    logic               HREADY;
    logic [N-1:0]       GRANT;
    logic [N-1:0]       GRANTD;
    AHBManager          outRequest;

    always #5 HCLK = ~HCLK;

    ahb_arbiter #(.NUM_MANAGERS(N), .RESET_OWNER(0)) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .inRequest  (inRequest),
        .HSEL       (HSEL),
        .HREADY     (HREADY),
        .GRANT      (GRANT),
        .GRANTD     (GRANTD),
        .outRequest (outRequest)
    );

    typedef struct {
        logic [N-1:0] grant;
        logic [N-1:0] grantd;
        logic [1:0]   htrans;
        logic [31:0]  haddr;
        logic [31:0]  hwdata;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    int   m_owner, m_rr, m_didx;
    bit   m_dv;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_rr    = 0;
        m_dv    = 1'b0;
        m_didx  = 0;
        sb_q.delete();
    endtask

    task automatic drive(input int i, input logic [1:0] t, input logic [31:0] a, input logic sel = 1'b1);
        inRequest[i].HADDR  = a;
        inRequest[i].HTRANS = t;
        inRequest[i].HWRITE = 1'b1;
        inRequest[i].HSIZE  = 3'd2;
        inRequest[i].HBURST = 3'd0;
        inRequest[i].HPROT  = 4'd3;
        inRequest[i].HWDATA = 32'hDA7A_0000 ^ a ^ (i << 28);
        HSEL[i]             = sel;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) drive(i, HTRANS_IDLE, 32'h0);
    endtask

    // Called at a falling edge with inputs already applied; returns at the next falling edge.
    task automatic cycle(input int want_grant = -1, input int want_ht = -1);
        exp_t         e, got;
        bit           act [N];
        int           nxt;
        logic [N-1:0] one = 1;
        for (int i = 0; i < N; i++)
            act[i] = HSEL[i] && (inRequest[i].HTRANS != HTRANS_IDLE);
        e.grant  = one << m_owner;
        e.grantd = m_dv ? (one << m_didx) : '0;
        e.htrans = act[m_owner] ? inRequest[m_owner].HTRANS : HTRANS_IDLE;
        e.haddr  = inRequest[m_owner].HADDR;
        e.hwdata = m_dv ? inRequest[m_didx].HWDATA : 32'h0;
        sb_q.push_back(e);

        nxt = m_owner;
        if (!(act[m_owner] && inRequest[m_owner].HTRANS == HTRANS_SEQ)) begin
`ifdef AHB_ARB_FIXED_PRIORITY_EN
            for (int c = N - 1; c >= 0; c--) if (act[c]) nxt = c;
`else
            for (int k = N; k >= 1; k--) if (act[(m_rr + k) % N]) nxt = (m_rr + k) % N;
`endif
        end

        #2;
        got = sb_q.pop_front();
        chk("GRANT",  32'(GRANT),             32'(got.grant));
        chk("GRANTD", 32'(GRANTD),            32'(got.grantd));
        chk("HTRANS", 32'(outRequest.HTRANS), 32'(got.htrans));
        chk("HADDR",  outRequest.HADDR,       got.haddr);
        chk("HWDATA", outRequest.HWDATA,      got.hwdata);
        if (want_grant >= 0) chk("want_grant", 32'(GRANT), 32'(want_grant));
        if (want_ht >= 0)    chk("want_htrans", 32'(outRequest.HTRANS), 32'(want_ht));

        @(posedge HCLK);
        if (HREADY) begin
            m_dv   = act[m_owner];
            m_didx = m_owner;
            if (nxt != m_owner) m_rr = nxt;
            m_owner = nxt;
        end
        @(negedge HCLK);
        cyc++;
    endtask

    initial begin
        HRESETn = 1'b0;
        HREADY  = 1'b1;
        idle_all();
        drive(0, HTRANS_NONSEQ, 32'h100);
        model_reset();
        #1;
        chk("rst_grant",  32'(GRANT),             32'h1);
        chk("rst_grantd", 32'(GRANTD),            32'h0);
        chk("rst_htrans", 32'(outRequest.HTRANS), 32'(HTRANS_IDLE));
        chk("rst_haddr",  outRequest.HADDR,       32'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;

        // Parked owner 0 is served with zero wait, then its data phase follows
        cycle(3'b001, HTRANS_NONSEQ);
        chk("first_haddr_seen", outRequest.HADDR, 32'h100);
        drive(0, HTRANS_IDLE, 32'h100);
        cycle(3'b001);

        // Two managers back-to-back single transfers alternate
        for (int k = 0; k < 8; k++) begin
            drive(0, HTRANS_NONSEQ, 32'h1000 + 4 * k);
            drive(1, HTRANS_NONSEQ, 32'h2000 + 4 * k);
            cycle();
        end

        // Four-beat burst from manager 0 while manager 1 waits
        idle_all();
        drive(0, HTRANS_NONSEQ, 32'h3000);
        for (int k = 0; k < 3 && m_owner != 0; k++) cycle();
        cycle(3'b001, HTRANS_NONSEQ);
        for (int b = 1; b < 4; b++) begin
            drive(0, HTRANS_SEQ, 32'h3000 + 4 * b);
            drive(1, HTRANS_NONSEQ, 32'h4000);
            cycle(3'b001, HTRANS_SEQ);
        end
        drive(0, HTRANS_IDLE, 32'h0);
        cycle(3'b001, HTRANS_IDLE);
        cycle(3'b010, HTRANS_NONSEQ);

        // Wait states during manager 1 data phase
        drive(1, HTRANS_IDLE, 32'h0);
        drive(0, HTRANS_NONSEQ, 32'h5000);
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle(3'b010);
            chk("stall_grantd", 32'(GRANTD), 32'h2);
        end
        HREADY = 1'b1;
        cycle(3'b010);
        drive(0, HTRANS_IDLE, 32'h0);
        drive(1, HTRANS_NONSEQ, 32'h6000);
        cycle(3'b001);

        // Parking on manager 1, then a zero-wait request from it
        idle_all();
        for (int k = 0; k < 5; k++) cycle(3'b010, HTRANS_IDLE);
        chk("park_grantd", 32'(GRANTD), 32'h0);
        drive(1, HTRANS_NONSEQ, 32'h200);
        cycle(3'b010, HTRANS_NONSEQ);

        // All three request continuously: strict rotation with wrap at 2
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < N; i++) drive(i, HTRANS_NONSEQ, 32'h7000 + (i << 8) + 4 * k);
            cycle();
        end

        // Deselected requests are ignored
        idle_all();
        drive(2, HTRANS_NONSEQ, 32'h8000, 1'b0);
        drive(0, HTRANS_NONSEQ, 32'h8100);
        repeat (3) cycle();

        // Random traffic including BUSY, SEQ, deselects and wait states
        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < N; i++)
                drive(i, 2'($urandom_range(0, 3)), $urandom & 32'hFFFC, ($urandom_range(0, 4) != 0));
            HREADY = ($urandom_range(0, 3) != 0);
            cycle();
        end
        HREADY = 1'b1;

        // Asynchronous reset in the middle of a manager 2 burst
        idle_all();
        drive(2, HTRANS_NONSEQ, 32'h9000);
        for (int k = 0; k < 4 && m_owner != 2; k++) cycle();
        cycle(3'b100, HTRANS_NONSEQ);
        drive(2, HTRANS_SEQ, 32'h9004);
        cycle(3'b100, HTRANS_SEQ);
        #3 HRESETn = 1'b0;
        #1;
        chk("arst_grant",  32'(GRANT),             32'h1);
        chk("arst_grantd", 32'(GRANTD),            32'h0);
        chk("arst_htrans", 32'(outRequest.HTRANS), 32'(HTRANS_IDLE));
        chk("arst_hwdata", outRequest.HWDATA,      32'h0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        model_reset();
        cycle(3'b001, HTRANS_IDLE);
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
